uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bit count; legal values 1 or 2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 txEn  input  1  transmitter enable.
REQ-008 txStart  input  1  request to send in_data; single-cycle or level.
REQ-009 in_data  input  DATA_BITS  payload, sampled on the accepting edge.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 txReady  output  1  holding register empty; a txStart will be accepted.
REQ-012 txBusy  output  1  a frame is on the line.
REQ-013 txDone  output  1  one-cycle pulse at the end of each frame.
REQ-014 txOverrun  output  1  one-cycle pulse when txStart is dropped.

Function
REQ-015 Frame: start bit (0), DATA_BITS payload LSB first, optional parity bit, STOP_BITS stop bits (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-016 Parity: even = XOR of payload; odd = inverted XOR; bit omitted when PARITY=0.
REQ-017 FSM states: IDLE, START, DATA, PAR, STOP; IDLE->START on load; START->DATA after one bit; DATA->PAR (PARITY!=0) or STOP after DATA_BITS bits; PAR->STOP after one bit; STOP->START if held data valid and txEn=1, else IDLE, after STOP_BITS bits.
REQ-018 Bit timer counts 0..CLKS_PER_BIT-1 and resets on every bit boundary; bit index counter sized for DATA_BITS.
REQ-019 Acceptance: txStart=1 and txEn=1 and txReady=1 at an edge.
REQ-020 If accepted while FSM is IDLE, data loads directly into the shifter and tx drives 0 from that same edge.
REQ-021 If accepted while a frame is active, data loads into the single-entry holding register and txReady drops at that edge.
REQ-022 Back-to-back: when the last stop bit ends with held data valid, the next start bit begins on the immediately following cycle (no idle bit), the holding register moves to the shifter, and txReady rises at that edge.
REQ-023 txStart=1 with txEn=1 and txReady=0 -> data ignored, txOverrun pulses one cycle; a level-held txStart pulses txOverrun every such cycle.
REQ-024 txBusy=1 for all non-IDLE states, including back-to-back gaps (stays 1 across frames).
REQ-025 txDone pulses on the final cycle of the last stop bit of each frame, concurrently with any back-to-back hand-over.
REQ-026 txEn=0 mid-frame: current frame completes; held data is retained and sent only after txEn returns to 1; no new acceptance while txEn=0.
REQ-027 in_data changes after the accepting edge have no effect on the frame.

Reset
REQ-028 rst=1 at any edge, including mid-frame: FSM->IDLE, counters 0, holding register invalid, tx=1, txReady=1, txBusy=0, txDone=0, txOverrun=0; the partial frame is abandoned.
REQ-029 First acceptance is possible on the first edge with rst=0.

Verification
REQ-030 Default 8N1, txStart pulse with 0xA5 -> tx low for 434 cycles, then bits 1,0,1,0,0,1,0,1 at 434 cycles each, then high; txDone at cycle 4340.
REQ-031 CLKS_PER_BIT=16, PARITY=1, STOP_BITS=2, send 0x3C -> 12-bit frame, parity bit 0, txDone after 192 cycles; PARITY=2 -> parity bit 1.
REQ-032 CLKS_PER_BIT=16, send 0x7F then 0x81 one cycle later -> txReady low until the first frame ends; second start bit directly follows the first stop bit; txBusy continuously 1; two txDone pulses 160 cycles apart.
REQ-033 Third txStart while a frame is active and the holding register is full -> txOverrun pulses once, and only two frames appear on tx.
REQ-034 Assert rst at bit 4 of a frame -> tx=1 and txBusy=0 the next cycle; a subsequent 0x55 transmits cleanly.
REQ-035 DATA_BITS=9, send 0x1FF with txEn dropped mid-frame -> frame completes with 9 ones; a held frame waits until txEn is reasserted.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first payload, optional parity, 1-2 stop bits; tx is registered.
// A single-entry holding register allows gapless back-to-back frames; a start while it is full is dropped and flagged.
module uart_tx_cfg #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 txEn,
   input  logic                 txStart,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 tx,
   output logic                 txReady,
   output logic                 txBusy,
   output logic                 txDone,
   output logic                 txOverrun
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] PAR   = 3'd3;
   localparam logic [2:0] STOP  = 3'd4;

   localparam int              IDX_W    = $clog2(DATA_BITS);
   localparam logic [15:0]     CNT_MAX  = 16'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);
   localparam logic            STOP_MAX = 1'(STOP_BITS - 1);
   localparam logic            PAR_ODD  = (PARITY == 2);

   logic [2:0]           state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_vld_q, hold_vld_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 ovr_q, ovr_d;

   logic                 accept, bit_end, load;
   logic [DATA_BITS-1:0] load_dat;

   assign accept  = txStart & txEn & ~hold_vld_q;
   assign bit_end = (cnt_q == CNT_MAX);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      par_d      = par_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      done_d     = 1'b0;
      ovr_d      = txStart & txEn & hold_vld_q;
      load       = 1'b0;
      load_dat   = in_data;
      tx_d       = 1'b1;

      if (state_q == IDLE) begin
         if (accept) begin
            load = 1'b1;
         end else if (hold_vld_q && txEn) begin
            load       = 1'b1;
            load_dat   = hold_q;
            hold_vld_d = 1'b0;
         end
      end else begin
         if (accept) begin
            hold_d     = in_data;
            hold_vld_d = 1'b1;
         end
         cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
         if (bit_end) begin
            case (state_q)
               START: begin
                  state_d = DATA;
                  idx_d   = '0;
               end
               DATA: begin
                  shift_d = shift_q >> 1;
                  if (idx_q == IDX_MAX) begin
                     state_d = (PARITY != 0) ? PAR : STOP;
                     stop_d  = 1'b0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
               PAR: begin
                  state_d = STOP;
                  stop_d  = 1'b0;
               end
               STOP: begin
                  if (stop_q == STOP_MAX) begin
                     done_d = 1'b1;
                     // Hand the held byte straight to the shifter so the next start bit follows with no idle gap.
                     if (hold_vld_q && txEn) begin
                        load       = 1'b1;
                        load_dat   = hold_q;
                        hold_vld_d = 1'b0;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     stop_d = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end

      if (load) begin
         state_d = START;
         cnt_d   = 16'd0;
         shift_d = load_dat;
         par_d   = (^load_dat) ^ PAR_ODD;
      end

      // tx is registered, so it is derived from the state being entered.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PAR:     tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         idx_q      <= '0;
         stop_q     <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
      end
   end

   assign tx        = tx_q;
   assign txReady   = ~hold_vld_q;
   assign txBusy    = (state_q != IDLE);
   assign txDone    = done_q;
   assign txOverrun = ovr_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five differently configured instances, a serial-line monitor per instance, and a frame scoreboard.
module tb_uart_tx_cfg;
   localparam int NI = 5;
   localparam int CPB  [NI] = '{434, 16, 16, 16, 16};
   localparam int DBA  [NI] = '{8, 8, 8, 8, 9};
   localparam int PARA [NI] = '{0, 1, 2, 0, 0};
   localparam int STBA [NI] = '{1, 2, 2, 1, 1};

   typedef struct {
      int         inst;
      logic [8:0] data;
   } exp_t;

   logic       clk;
   logic       rst_r   [NI];
   logic       en_r    [NI];
   logic       start_r [NI];
   logic [8:0] din_r   [NI];
   wire        tx_w    [NI];
   wire        rdy_w   [NI];
   wire        busy_w  [NI];
   wire        done_w  [NI];
   wire        ovr_w   [NI];

   exp_t exp_q [$];
   int   frames_seen [NI];
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_cfg #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DBA[0]), .PARITY(PARA[0]), .STOP_BITS(STBA[0])) u0 (
      .clk(clk), .rst(rst_r[0]), .txEn(en_r[0]), .txStart(start_r[0]), .in_data(din_r[0][7:0]),
      .tx(tx_w[0]), .txReady(rdy_w[0]), .txBusy(busy_w[0]), .txDone(done_w[0]), .txOverrun(ovr_w[0]));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DBA[1]), .PARITY(PARA[1]), .STOP_BITS(STBA[1])) u1 (
      .clk(clk), .rst(rst_r[1]), .txEn(en_r[1]), .txStart(start_r[1]), .in_data(din_r[1][7:0]),
      .tx(tx_w[1]), .txReady(rdy_w[1]), .txBusy(busy_w[1]), .txDone(done_w[1]), .txOverrun(ovr_w[1]));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DBA[2]), .PARITY(PARA[2]), .STOP_BITS(STBA[2])) u2 (
      .clk(clk), .rst(rst_r[2]), .txEn(en_r[2]), .txStart(start_r[2]), .in_data(din_r[2][7:0]),
      .tx(tx_w[2]), .txReady(rdy_w[2]), .txBusy(busy_w[2]), .txDone(done_w[2]), .txOverrun(ovr_w[2]));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(DBA[3]), .PARITY(PARA[3]), .STOP_BITS(STBA[3])) u3 (
      .clk(clk), .rst(rst_r[3]), .txEn(en_r[3]), .txStart(start_r[3]), .in_data(din_r[3][7:0]),
      .tx(tx_w[3]), .txReady(rdy_w[3]), .txBusy(busy_w[3]), .txDone(done_w[3]), .txOverrun(ovr_w[3]));
   uart_tx_cfg #(.CLKS_PER_BIT(CPB[4]), .DATA_BITS(DBA[4]), .PARITY(PARA[4]), .STOP_BITS(STBA[4])) u4 (
      .clk(clk), .rst(rst_r[4]), .txEn(en_r[4]), .txStart(start_r[4]), .in_data(din_r[4]),
      .tx(tx_w[4]), .txReady(rdy_w[4]), .txBusy(busy_w[4]), .txDone(done_w[4]), .txOverrun(ovr_w[4]));

   // Line monitor: decodes each frame at bit centres and retires it against the scoreboard.
   for (genvar g = 0; g < NI; g++) begin : g_mon
      initial begin
         logic [15:0] fr;
         logic [8:0]  d;
         int          nb;
         bit          ab;
         exp_t        e;
         nb = 1 + DBA[g] + ((PARA[g] != 0) ? 1 : 0) + STBA[g];
         forever begin
            @(negedge clk);
            while (!rst_r[g] && tx_w[g] === 1'b0) begin
               fr = '0;
               ab = 1'b0;
               for (int c = 0; c <= nb * CPB[g]; c++) begin
                  if (c > 0) @(negedge clk);
                  if (rst_r[g]) begin
                     ab = 1'b1;
                     break;
                  end
                  if (c < nb * CPB[g] && (c % CPB[g]) == CPB[g] / 2) fr[c / CPB[g]] = tx_w[g];
               end
               if (ab) break;
               d = '0;
               for (int b = 0; b < DBA[g]; b++) d[b] = fr[1 + b];
               checks++;
               if (fr[0] !== 1'b0) begin
                  failures++;
                  $display("FAIL mon%0d start_bit: got %b expected 0", g, fr[0]);
               end
               for (int s = 0; s < STBA[g]; s++) begin
                  checks++;
                  if (fr[nb - STBA[g] + s] !== 1'b1) begin
                     failures++;
                     $display("FAIL mon%0d stop_bit%0d: got %b expected 1", g, s, fr[nb - STBA[g] + s]);
                  end
               end
               checks++;
               if (done_w[g] !== 1'b1) begin
                  failures++;
                  $display("FAIL mon%0d done_at_frame_end: got %b expected 1", g, done_w[g]);
               end
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL mon%0d unexpected_frame: got data %0h expected no frame", g, d);
               end else begin
                  e = exp_q.pop_front();
                  if (e.inst != g || e.data !== d) begin
                     failures++;
                     $display("FAIL mon%0d frame_data: got inst %0d data %0h expected inst %0d data %0h",
                              g, g, d, e.inst, e.data);
                  end
               end
               frames_seen[g]++;
            end
         end
      end
   end

   function automatic exp_t mk_exp(input int g, input logic [8:0] data);
      exp_t e;
      e.inst = g;
      e.data = data & (9'h1FF >> (9 - DBA[g]));
      return e;
   endfunction

   // Send one frame; the cycle after the accepting edge is t=0.
   task automatic run_frame(input int g, input logic [8:0] data, input bit rel_rst,
                            input int exp_done, input int probe_c, input logic probe_v);
      int dt;
      dt = -1;
      start_r[g] = 1'b1;
      din_r[g]   = data;
      if (rel_rst) rst_r[g] = 1'b0;
      exp_q.push_back(mk_exp(g, data));
      @(posedge clk);
      for (int t = 0; t < 6000 && dt < 0; t++) begin
         @(negedge clk);
         if (t == 0) begin
            start_r[g] = 1'b0;
            din_r[g]   = ~data;
            checks++;
            if (tx_w[g] !== 1'b0 || busy_w[g] !== 1'b1) begin
               failures++;
               $display("FAIL frame%0d start_edge: got tx %b busy %b expected tx 0 busy 1", g, tx_w[g], busy_w[g]);
            end
         end
         if (t == probe_c) begin
            checks++;
            if (tx_w[g] !== probe_v) begin
               failures++;
               $display("FAIL frame%0d probe_t%0d: got %b expected %b", g, t, tx_w[g], probe_v);
            end
         end
         if (t == exp_done - 1) begin
            checks++;
            if (tx_w[g] !== 1'b1 || done_w[g] !== 1'b0) begin
               failures++;
               $display("FAIL frame%0d last_stop_cycle: got tx %b done %b expected tx 1 done 0", g, tx_w[g], done_w[g]);
            end
         end
         if (done_w[g] === 1'b1) dt = t;
      end
      checks++;
      if (dt != exp_done) begin
         failures++;
         $display("FAIL frame%0d done_cycle: got %0d expected %0d", g, dt, exp_done);
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL frame%0d scoreboard_drained: got %0d pending expected 0", g, exp_q.size());
      end
   endtask

   task automatic test_reset();
      for (int g = 0; g < NI; g++) begin
         rst_r[g] = 1'b1; en_r[g] = 1'b1; start_r[g] = 1'b0; din_r[g] = 9'h0;
         frames_seen[g] = 0;
      end
      start_r[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         checks++;
         if (tx_w[g] !== 1'b1 || rdy_w[g] !== 1'b1 || busy_w[g] !== 1'b0 ||
             done_w[g] !== 1'b0 || ovr_w[g] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state%0d: got tx %b rdy %b busy %b done %b ovr %b expected 1 1 0 0 0",
                     g, tx_w[g], rdy_w[g], busy_w[g], done_w[g], ovr_w[g]);
         end
      end
      start_r[1] = 1'b0;
      for (int g = 1; g < NI; g++) rst_r[g] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      run_frame(0, 9'h0A5, 1'b1, 4340, 434, 1'b1);
   endtask

   task automatic test_parity();
      run_frame(1, 9'h03C, 1'b0, 192, 152, 1'b0);
      run_frame(2, 9'h03C, 1'b0, 192, 152, 1'b1);
   endtask

   task automatic test_back_to_back();
      int d1, d2, rdy_bad, busy_bad, f0;
      d1 = -1; d2 = -1; rdy_bad = 0; busy_bad = 0; f0 = frames_seen[3];
      for (int t = 0; t < 400; t++) begin
         start_r[3] = (t <= 1);
         din_r[3]   = (t == 0) ? 9'h07F : (t == 1) ? 9'h081 : 9'h000;
         if (t <= 1) exp_q.push_back(mk_exp(3, din_r[3]));
         @(posedge clk);
         @(negedge clk);
         if (t >= 1 && t < 160 && rdy_w[3] !== 1'b0) rdy_bad++;
         if (t < 320 && busy_w[3] !== 1'b1) busy_bad++;
         if (t == 160) begin
            checks++;
            if (tx_w[3] !== 1'b0 || rdy_w[3] !== 1'b1) begin
               failures++;
               $display("FAIL b2b_handover: got tx %b rdy %b expected tx 0 rdy 1", tx_w[3], rdy_w[3]);
            end
         end
         if (done_w[3] === 1'b1) begin
            if (d1 < 0) d1 = t;
            else if (d2 < 0) d2 = t;
         end
      end
      checks++;
      if (d1 != 160 || d2 != 320) begin
         failures++;
         $display("FAIL b2b_done_cycles: got %0d,%0d expected 160,320", d1, d2);
      end
      checks++;
      if (rdy_bad != 0 || busy_bad != 0) begin
         failures++;
         $display("FAIL b2b_flags: got rdy_bad %0d busy_bad %0d expected 0 0", rdy_bad, busy_bad);
      end
      checks++;
      if (frames_seen[3] - f0 != 2 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_frames: got %0d frames %0d pending expected 2 frames 0 pending",
                  frames_seen[3] - f0, exp_q.size());
      end
   endtask

   task automatic test_overrun();
      int ovr_cnt, f0;
      ovr_cnt = 0; f0 = frames_seen[3];
      for (int t = 0; t < 400; t++) begin
         start_r[3] = (t <= 2) || (t == 10) || (t == 11);
         din_r[3]   = (t == 0) ? 9'h012 : (t == 1) ? 9'h034 : 9'h056;
         if (t <= 1) exp_q.push_back(mk_exp(3, din_r[3]));
         @(posedge clk);
         @(negedge clk);
         if (ovr_w[3] === 1'b1) ovr_cnt++;
         if (t == 2 || t == 3) begin
            checks++;
            if (ovr_w[3] !== (t == 2)) begin
               failures++;
               $display("FAIL overrun_pulse_t%0d: got %b expected %b", t, ovr_w[3], (t == 2));
            end
         end
      end
      checks++;
      if (ovr_cnt != 3) begin
         failures++;
         $display("FAIL overrun_count: got %0d expected 3", ovr_cnt);
      end
      checks++;
      if (frames_seen[3] - f0 != 2 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL overrun_frames: got %0d frames %0d pending expected 2 frames 0 pending",
                  frames_seen[3] - f0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int busy_bad;
      busy_bad = 0;
      for (int t = 0; t <= 70; t++) begin
         start_r[3] = (t <= 1);
         din_r[3]   = (t == 0) ? 9'h0F0 : 9'h0AA;
         rst_r[3]   = (t == 70);
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (tx_w[3] !== 1'b1 || busy_w[3] !== 1'b0 || rdy_w[3] !== 1'b1 || done_w[3] !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: got tx %b busy %b rdy %b done %b expected 1 0 1 0",
                  tx_w[3], busy_w[3], rdy_w[3], done_w[3]);
      end
      rst_r[3] = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (busy_w[3] !== 1'b0 || tx_w[3] !== 1'b1) busy_bad++;
      end
      checks++;
      if (busy_bad != 0) begin
         failures++;
         $display("FAIL reset_clears_hold: got %0d active cycles expected 0", busy_bad);
      end
      run_frame(3, 9'h055, 1'b0, 160, 24, 1'b1);
   endtask

   task automatic test_en_mid();
      int d1, d2, gap_bad;
      d1 = -1; d2 = -1; gap_bad = 0;
      for (int t = 0; t < 480; t++) begin
         start_r[4] = (t <= 1) || (t == 60);
         din_r[4]   = (t == 0) ? 9'h1FF : (t == 1) ? 9'h0AA : 9'h133;
         en_r[4]    = !(t >= 50 && t < 250);
         if (t <= 1) exp_q.push_back(mk_exp(4, din_r[4]));
         @(posedge clk);
         @(negedge clk);
         if (t >= 180 && t < 250 && (busy_w[4] !== 1'b0 || tx_w[4] !== 1'b1)) gap_bad++;
         if (t == 60) begin
            checks++;
            if (ovr_w[4] !== 1'b0) begin
               failures++;
               $display("FAIL en_low_no_overrun: got %b expected 0", ovr_w[4]);
            end
         end
         if (t == 200) begin
            checks++;
            if (rdy_w[4] !== 1'b0) begin
               failures++;
               $display("FAIL en_low_hold_kept: got rdy %b expected 0", rdy_w[4]);
            end
         end
         if (t == 250) begin
            checks++;
            if (tx_w[4] !== 1'b0) begin
               failures++;
               $display("FAIL en_resume_start: got tx %b expected 0", tx_w[4]);
            end
         end
         if (done_w[4] === 1'b1) begin
            if (d1 < 0) d1 = t;
            else if (d2 < 0) d2 = t;
         end
      end
      checks++;
      if (d1 != 176 || d2 != 426 || gap_bad != 0) begin
         failures++;
         $display("FAIL en_mid_timing: got done %0d,%0d gap_bad %0d expected 176,426 0", d1, d2, gap_bad);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL en_mid_frames: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_en_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
